parking_gate_controller: RTL
============================

Name: parking_gate_controller

Overview:
- Sequential block that produces the increment and decrement operations applied to the 4-bit occupancy count.
- Detects car-entry and car-exit sensor events, arbitrates them and checks capacity.
- Updates the registered occupancy count by +1 or -1 using the team's 4-bit adder/subtractor, and drives the entry and exit gate-open outputs for a fixed hold time.
- Sits between the lot sensors and the display/status logic.

Parameters:
- CAPACITY, 15: maximum occupancy; legal range 1..15.
- GATE_CYCLES, 8: cycles a gate stays open per accepted event; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enter_sensor  input  1  entry loop sensor, level; already synchronous to clk.
- exit_sensor  input  1  exit loop sensor, level; already synchronous to clk.
- count  output  4  registered current occupancy.
- full  output  1  registered; 1 when count == CAPACITY.
- empty  output  1  registered; 1 when count == 0.
- gate_in_open  output  1  registered; entry gate open command.
- gate_out_open  output  1  registered; exit gate open command.
- deny  output  1  registered one-cycle pulse; event rejected.
- deny_code  output  1  valid with deny: 0 = entry refused (full), 1 = exit refused (empty).

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, count=0, full=0, empty=1, gate_in_open=0, gate_out_open=0, deny=0, deny_code=0.
  - Sensor history registers and pending flags are cleared.
  - A reset mid-operation closes both gates immediately and discards pending events.
- Edge detect:
  - Each sensor has a history register.
  - A rising edge means sensor=1 at this clock edge and history=0.
  - A rising edge sets pend_in or pend_out at that same clock edge.
  - A held-high sensor produces exactly one event.
- Pending flags:
  - Depth 1 per direction. Further edges while a flag is set are coalesced and dropped.
  - A flag clears on the clock edge where the FSM services it.
  - If service and a new edge for the same direction occur on the same clock edge, the flag stays set.
- FSM states: IDLE, OPEN_IN, OPEN_OUT, DENY.
- IDLE:
  - Exit has priority over entry, so a departing car frees space first.
  - pend_out and count==0 -> DENY, deny_code=1.
  - pend_out and count>0 -> OPEN_OUT, count<=count-1.
  - Otherwise pend_in and count==CAPACITY -> DENY, deny_code=0.
  - pend_in and count<CAPACITY -> OPEN_IN, count<=count+1.
  - No pending flag -> remain in IDLE.
- OPEN_IN / OPEN_OUT:
  - The matching gate output is 1 for exactly GATE_CYCLES cycles, timed by an 8-bit hold counter loaded on entry to the state.
  - Then return to IDLE, where the gate is 0.
  - IDLE lasts at least one cycle between services.
  - Events arriving during OPEN are latched, not lost, subject to depth-1.
- DENY:
  - deny=1 for exactly one cycle; count unchanged; then IDLE.
- Arithmetic:
  - count updates through the 4-bit adder/subtractor (sel=0 for add, sel=1 for subtract, B=1).
  - The capacity checks above guarantee no wrap past 15 or below 0; carry-out is ignored.
  - full and empty are registered from the next count, so they change on the same edge as count.
- Latency: sensor rising edge at edge t -> pend set at t -> count and gate update at edge t+1, given FSM in IDLE at t.

Test Plan:
- Reset then single entry pulse:
  - count 0->1 one cycle after the edge; gate_in_open high for 8 cycles; empty falls with the count change.
  - Then exit pulse -> count 0, gate_out_open high for 8 cycles, empty=1.
- Fill to capacity with 15 spaced entries -> count=15 and full=1. A 16th entry -> deny pulse of 1 cycle, deny_code=0, count stays 15, no gate.
- Exit at count=0 -> deny=1 for 1 cycle, deny_code=1, count stays 0.
- Entry and exit edges on the same cycle at count=5:
  - OPEN_OUT first, count=4, 8 cycles.
  - One IDLE cycle.
  - OPEN_IN, count=5.
- Three entry edges during an OPEN_IN window, with enter_sensor held high 20 cycles at one point:
  - Exactly one extra entry is serviced; total count increments by 2.
  - The held-high sensor produces one event.
- Assert rst_n low mid-OPEN_IN, asynchronously between clock edges -> outputs return to reset values immediately and count=0. After release, no stale pending event is serviced.

Source files
------------

// File: rtl/parking_gate_controller_if.sv
// Sensor-side / controller-side bundle for the parking gate controller.
// master = lot sensors and status consumers, slave = the controller.
interface parking_gate_controller_if;
  logic       enter_sensor;
  logic       exit_sensor;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       gate_in_open;
  logic       gate_out_open;
  logic       deny;
  logic       deny_code;

  modport master (
    output enter_sensor, exit_sensor,
    input  count, full, empty, gate_in_open, gate_out_open, deny, deny_code
  );

  modport slave (
    input  enter_sensor, exit_sensor,
    output count, full, empty, gate_in_open, gate_out_open, deny, deny_code
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Parking lot gate controller: edge-detects entry/exit sensors, arbitrates
// them (exit first), tracks 4-bit occupancy and times the gate-open outputs.
module parking_gate_controller #(
  parameter int unsigned CAPACITY    = 15,
  parameter int unsigned GATE_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  parking_gate_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, DENY} state_t;

  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [7:0] HOLD_LOAD = 8'(GATE_CYCLES - 1);

  state_t     state_q;
  logic       enter_hist_q, exit_hist_q;
  logic       pend_in_q, pend_out_q;
  logic       pend_in_d, pend_out_d;
  logic       rise_in, rise_out, svc_in, svc_out;
  logic [3:0] count_q;
  logic [7:0] hold_q;
  logic       full_q, empty_q, gate_in_q, gate_out_q, deny_q, deny_code_q;
  logic       addsub_sel;
  logic [3:0] addsub_b, addsub_sum;

  always_comb begin
    rise_in    = bus.enter_sensor & ~enter_hist_q;
    rise_out   = bus.exit_sensor  & ~exit_hist_q;
    svc_out    = (state_q == IDLE) & pend_out_q;
    svc_in     = (state_q == IDLE) & pend_in_q & ~pend_out_q;
    // a fresh edge on the service edge keeps the flag set
    pend_in_d  = (pend_in_q  & ~svc_in)  | rise_in;
    pend_out_d = (pend_out_q & ~svc_out) | rise_out;
    // 4-bit adder/subtractor, B=1; sel=1 subtracts via B inversion plus carry-in
    addsub_sel = pend_out_q;
    addsub_b   = 4'd1 ^ {4{addsub_sel}};
    addsub_sum = count_q + addsub_b + {3'b000, addsub_sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      enter_hist_q <= 1'b0;
      exit_hist_q  <= 1'b0;
      pend_in_q    <= 1'b0;
      pend_out_q   <= 1'b0;
      count_q      <= '0;
      hold_q       <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      gate_in_q    <= 1'b0;
      gate_out_q   <= 1'b0;
      deny_q       <= 1'b0;
      deny_code_q  <= 1'b0;
    end else begin
      enter_hist_q <= bus.enter_sensor;
      exit_hist_q  <= bus.exit_sensor;
      pend_in_q    <= pend_in_d;
      pend_out_q   <= pend_out_d;
      deny_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_out_q) begin
            if (count_q == 4'd0) begin
              state_q     <= DENY;
              deny_q      <= 1'b1;
              deny_code_q <= 1'b1;
            end else begin
              state_q    <= OPEN_OUT;
              gate_out_q <= 1'b1;
              hold_q     <= HOLD_LOAD;
              count_q    <= addsub_sum;
              full_q     <= (addsub_sum == CAP);
              empty_q    <= (addsub_sum == 4'd0);
            end
          end else if (pend_in_q) begin
            if (count_q == CAP) begin
              state_q     <= DENY;
              deny_q      <= 1'b1;
              deny_code_q <= 1'b0;
            end else begin
              state_q   <= OPEN_IN;
              gate_in_q <= 1'b1;
              hold_q    <= HOLD_LOAD;
              count_q   <= addsub_sum;
              full_q    <= (addsub_sum == CAP);
              empty_q   <= (addsub_sum == 4'd0);
            end
          end
        end
        OPEN_IN: begin
          if (hold_q == 8'd0) begin
            state_q   <= IDLE;
            gate_in_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        OPEN_OUT: begin
          if (hold_q == 8'd0) begin
            state_q    <= IDLE;
            gate_out_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        DENY:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count         = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.gate_in_open  = gate_in_q;
  assign bus.gate_out_open = gate_out_q;
  assign bus.deny          = deny_q;
  assign bus.deny_code     = deny_code_q;

endmodule
